// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage.
// Issues word-aligned fetches on a req/gnt/rvalid port, buffers returned words
// in a DEPTH-entry FIFO and hands {opcode, pc} to the Decoder via valid/ready.
// Redirects flush the FIFO and drop in-flight responses via drop_cnt.
// Optional: define FETCH_MISALIGN_CHECK_EN to add o_fetch_fault and a FAULT
// state entered on a misaligned redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_addr,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_opcode,
  output logic [31:0] o_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        o_fetch_fault
`endif
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FAULT} state_e;
`else
  typedef enum logic [1:0] {S_BOOT, S_RUN} state_e;
`endif

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d, last_pc_q, last_pc_d;
  logic [CW-1:0]   cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d, twr_q, twr_d, trd_q, trd_d;
  logic [31:0]     op_mem  [DEPTH];
  logic [31:0]     pcf_mem [DEPTH];
  logic [31:0]     tag_mem [DEPTH];
  logic [CW:0]     inflight;
  logic            pop, push, grant, drop_resp;

  // Handshake, credit and output decode.
  always_comb begin
    o_valid     = (cnt_q != '0) & ~i_redirect;
    pop         = o_valid & i_ready;
    // Entries buffered plus words still owed by memory, net of this cycle's pop.
    inflight    = {1'b0, cnt_q} + {1'b0, out_q} - (CW+1)'(pop);
    o_imem_req  = (state_q == S_RUN) & ~i_redirect & (inflight < (CW+1)'(DEPTH));
    o_imem_addr = pc_q;
    grant       = o_imem_req & i_imem_gnt;
    drop_resp   = i_imem_rvalid & (drop_q != '0);
    push        = i_imem_rvalid & (drop_q == '0) & ~i_redirect;
    o_opcode    = o_valid ? op_mem[rd_q]  : NOP;
    o_pc        = o_valid ? pcf_mem[rd_q] : last_pc_q;
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  assign o_fetch_fault = (state_q == S_FAULT);
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^i_redirect_addr[1:0];
`endif

  // Next-state: redirect overrides every other event in its cycle.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    out_d     = out_q + CW'(grant) - CW'(i_imem_rvalid);
    drop_d    = drop_q - CW'(drop_resp);
    wr_d      = wr_q;
    rd_d      = rd_q;
    twr_d     = twr_q;
    trd_d     = trd_q;
    last_pc_d = o_pc;
    if (state_q == S_BOOT) state_d = S_RUN;
    if (i_redirect) begin
      pc_d   = {i_redirect_addr[31:2], 2'b00};
      cnt_d  = '0;
      wr_d   = '0;
      rd_d   = '0;
      twr_d  = '0;
      trd_d  = '0;
      // Everything still owed by memory after this cycle is stale.
      drop_d = out_q - CW'(i_imem_rvalid);
`ifdef FETCH_MISALIGN_CHECK_EN
      state_d = (i_redirect_addr[1:0] != 2'b00) ? S_FAULT : S_RUN;
`endif
    end else begin
      if (grant) begin
        pc_d  = pc_q + 32'd4;
        twr_d = twr_q + AW'(1);
      end
      if (push) begin
        wr_d  = wr_q + AW'(1);
        trd_d = trd_q + AW'(1);
      end
      if (pop) rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      last_pc_q <= RESET_PC;
      cnt_q     <= '0;
      out_q     <= '0;
      drop_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      twr_q     <= '0;
      trd_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      last_pc_q <= last_pc_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      twr_q     <= twr_d;
      trd_q     <= trd_d;
    end
  end

  // Data storage: PC tag captured at grant, word+tag written at response.
  always_ff @(posedge i_clk) begin
    if (grant) tag_mem[twr_q] <= pc_q;
    if (push) begin
      op_mem[wr_q]  <= i_imem_rdata;
      pcf_mem[wr_q] <= tag_mem[trd_q];
    end
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the RV32I core, directly upstream of the Decoder.
- Generates the word-aligned PC and drives a simple request/grant/response instruction-memory port.
- Buffers returned words in a small FIFO and presents {opcode, pc} pairs to the Decoder over a valid/ready handshake.
- Accepts jump/branch redirects, flushing buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h80000000, first fetch address after reset
DEPTH, 2, FIFO entries and maximum outstanding requests; power of two, 2 or larger

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
o_imem_req  out  1  fetch request
o_imem_addr  out  32  fetch address, bits [1:0] always 0
i_imem_gnt  in  1  request accepted this cycle when o_imem_req=1
i_imem_rvalid  in  1  response word valid; responses arrive in order, at least 1 cycle after grant
i_imem_rdata  in  32  instruction word
i_redirect  in  1  jump taken; single-cycle pulse
i_redirect_addr  in  32  new PC
o_valid  out  1  o_opcode/o_pc valid toward Decoder
i_ready  in  1  Decoder consumes the entry
o_opcode  out  32  instruction word, equals FIFO head
o_pc  out  32  address of o_opcode
o_fetch_fault  out  1  misaligned redirect; present only with FETCH_MISALIGN_CHECK_EN

Behaviour:
- Reset is asynchronous, active-low; clock is i_clk.
- Reset values: fetch PC=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=BOOT, o_valid=0, o_imem_req=0, o_opcode=32'h00000013 (nop), o_pc=RESET_PC, o_fetch_fault=0.
- States:
  - BOOT: one idle cycle after reset release, then RUN.
  - RUN: normal fetching.
  - FAULT: exists only with the macro.
- Request issue in RUN:
  - o_imem_req=1 when !i_redirect and (count + outstanding - pop) < DEPTH, where pop = o_valid & i_ready.
  - o_imem_addr = fetch PC.
  - Once asserted, req and addr hold stable until granted, unless a redirect occurs.
- Grant (req & gnt): PC <= PC+4, wrapping 32'hFFFFFFFC to 0; outstanding +1.
- Response (rvalid):
  - outstanding -1.
  - If drop_cnt>0: word discarded, drop_cnt -1.
  - Otherwise word pushed with the PC captured at grant; an internal PC-tag FIFO of DEPTH entries carries the PC from grant to response.
- Push and pop in the same cycle are both allowed; a push is never presented when the FIFO is full, guaranteed by the credit rule.
- o_valid = (count != 0) & !i_redirect.
- While o_valid=0, o_opcode=nop and o_pc holds its last value.
- Throughput: with gnt tied 1, 1-cycle response latency, and i_ready=1, the block sustains 1 instruction per cycle after a 3-cycle startup.
- Redirect cycle (i_redirect=1), taking priority over every other event:
  - No request issued.
  - FIFO and tag FIFO cleared.
  - drop_cnt <= outstanding - (rvalid this cycle); a response arriving in this cycle is discarded.
  - PC <= {i_redirect_addr[31:2], 2'b00}.
  - Any handshake in this cycle is ignored.
  - Next cycle fetches the new PC.
- Redirect during BOOT: PC updates and BOOT completes normally.
- A redirect while drop_cnt>0 accumulates correctly: drop_cnt = total outstanding.
- Reset asserted mid-operation returns all state to reset values immediately; pending responses after reset are the memory's responsibility (memory is also reset).

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined:
  - A redirect with i_redirect_addr[1:0]!=0 flushes as normal, then enters FAULT.
  - In FAULT: o_fetch_fault=1, no requests issued, outstanding responses drained via drop_cnt.
  - Only an aligned redirect exits FAULT to RUN; a further misaligned redirect stays in FAULT.
- Undefined:
  - No o_fetch_fault port and no FAULT state.
  - Address bits [1:0] are silently cleared.

Test Plan:
1. Reset release, gnt=1, 1-cycle rvalid returning mem[a]=a^32'h13, i_ready=1 -> o_pc sequence 80000000, 80000004, 80000008… with no bubbles after the first valid; o_opcode matches.
2. i_ready=0 for 10 cycles -> at most DEPTH grants, o_imem_req drops, o_valid stays 1 with o_pc=80000000 held; on release, in-order delivery with no loss or duplication.
3. gnt low for 3 cycles -> o_imem_req and o_imem_addr=80000000 stable throughout; address advances only after grant.
4. i_redirect to 80000100 with 2 requests outstanding -> both responses discarded; next delivered o_pc=80000100; no stale entry ever has o_valid=1.
5. Redirect to FFFFFFFC -> o_pc sequence FFFFFFFC, 00000000, 00000004.
6. With FETCH_MISALIGN_CHECK_EN, redirect to 80000102 -> o_fetch_fault=1 and o_imem_req=0; a later redirect to 80000200 -> fault clears and o_pc=80000200 is delivered.
